// File: rtl/match_counter_pkg.sv
// Shared types for the wildcard-rule match counter.
// Optional status feature: MATCH_COUNTER_STATUS_EN.
package match_counter_pkg;

  localparam int ACTION_W = 2;
  localparam int MAX_W    = 32;

  typedef enum logic [ACTION_W-1:0] {
    ACT_INC   = 2'b00,
    ACT_CLEAR = 2'b01,
    ACT_LOAD  = 2'b10,
    ACT_HOLD  = 2'b11
  } action_t;

  // Fields are sized for the widest counter and zero-extended.
  typedef struct packed {
    logic             valid;
    logic [MAX_W-1:0] value;
    logic [MAX_W-1:0] mask;
    action_t          action;
    logic [MAX_W-1:0] load;
  } rule_t;

endpackage

// File: rtl/match_counter_rule.sv
// One match rule: storage, write decode and wildcard compare.
// Zero-extension keeps upper field bits neutral in the compare.
module match_counter_rule
  import match_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IW    = 2,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [WIDTH-1:0] cfg_value,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [1:0]       cfg_action,
  input  logic [WIDTH-1:0] cfg_load,
  input  logic             cfg_enable,
  input  logic [WIDTH-1:0] led,
  output logic             hit,
  output action_t          act,
  output logic [WIDTH-1:0] load
);

  rule_t            rule_q;
  logic [MAX_W-1:0] led_ext;

  // Capture the rule when this slot is addressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rule_q <= '0;
    end else if (cfg_we && cfg_idx == IW'(IDX)) begin
      rule_q.valid  <= cfg_enable;
      rule_q.value  <= MAX_W'(cfg_value);
      rule_q.mask   <= MAX_W'(cfg_mask);
      rule_q.action <= action_t'(cfg_action);
      rule_q.load   <= MAX_W'(cfg_load);
    end
  end

  assign led_ext = MAX_W'(led);
  assign hit  = rule_q.valid &&
                (((led_ext ^ rule_q.value) & rule_q.mask) == '0);
  assign act  = rule_q.action;
  assign load = WIDTH'(rule_q.load);

endmodule

// File: rtl/match_counter.sv
// Counter steered by a prioritised table of wildcard rules.
// MATCH_COUNTER_STATUS_EN adds sticky per-rule hit flags.
module match_counter
  import match_counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_RULES = 4,
  parameter int STEP      = 1,
  localparam int IW = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             CFG_WE,
  input  logic [IW-1:0]    CFG_IDX,
  input  logic [WIDTH-1:0] CFG_VALUE,
  input  logic [WIDTH-1:0] CFG_MASK,
  input  logic [1:0]       CFG_ACTION,
  input  logic [WIDTH-1:0] CFG_LOAD,
  input  logic             CFG_ENABLE,
  output logic [WIDTH-1:0] LED,
  output logic             MATCH,
  output logic [IW-1:0]    MATCH_IDX
`ifdef MATCH_COUNTER_STATUS_EN
  ,
  input  logic                 STICKY_CLR,
  output logic [NUM_RULES-1:0] STICKY_HIT
`endif
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [NUM_RULES-1:0] hits;
  action_t              acts  [NUM_RULES];
  logic [WIDTH-1:0]     loads [NUM_RULES];

  logic [WIDTH-1:0] led_q;
  logic [WIDTH-1:0] led_nxt;
  logic             any;
  logic [IW-1:0]    win;
  action_t          act_sel;
  logic [WIDTH-1:0] load_sel;

  for (genvar g = 0; g < NUM_RULES; g++) begin : g_rule
    match_counter_rule #(
      .WIDTH(WIDTH),
      .IW   (IW),
      .IDX  (g)
    ) u_rule (
      .clk       (CLK),
      .rst_n     (RST_N),
      .cfg_we    (CFG_WE),
      .cfg_idx   (CFG_IDX),
      .cfg_value (CFG_VALUE),
      .cfg_mask  (CFG_MASK),
      .cfg_action(CFG_ACTION),
      .cfg_load  (CFG_LOAD),
      .cfg_enable(CFG_ENABLE),
      .led       (led_q),
      .hit       (hits[g]),
      .act       (acts[g]),
      .load      (loads[g])
    );
  end

  // Lowest-index hit wins; no hit falls back to INC
  always_comb begin
    any      = 1'b0;
    win      = '0;
    act_sel  = ACT_INC;
    load_sel = '0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (hits[i]) begin
        any      = 1'b1;
        win      = IW'(i);
        act_sel  = acts[i];
        load_sel = loads[i];
      end
    end
  end

  // Next count from the winning action
  always_comb begin
    led_nxt = led_q;
    unique case (act_sel)
      ACT_INC:   led_nxt = led_q + STEP_W;
      ACT_CLEAR: led_nxt = '0;
      ACT_LOAD:  led_nxt = load_sel;
      ACT_HOLD:  led_nxt = led_q;
    endcase
  end

  // Count register, advances only when enabled
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      led_q <= '0;
    end else if (EN) begin
      led_q <= led_nxt;
    end
  end

  assign LED       = led_q;
  assign MATCH     = any;
  assign MATCH_IDX = win;

`ifdef MATCH_COUNTER_STATUS_EN
  logic [NUM_RULES-1:0] sticky_q;
  logic [NUM_RULES-1:0] set_vec;

  // One-hot of the rule that acts on this edge
  always_comb begin
    set_vec = '0;
    if (EN && any) begin
      set_vec[win] = 1'b1;
    end
  end

  // Sticky flags; a new hit beats a same-cycle clear
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (STICKY_CLR ? '0 : sticky_q) | set_vec;
    end
  end

  assign STICKY_HIT = sticky_q;
`endif

endmodule

// File: tb/tb_match_counter.sv
// Directed scoreboard bench for match_counter.
// WIDTH=8, NUM_RULES=4, STEP=1.
module tb_match_counter;
  import match_counter_pkg::*;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          CLK        = 1'b0;
  logic          RST_N      = 1'b0;
  logic          EN         = 1'b0;
  logic          CFG_WE     = 1'b0;
  logic [IW-1:0] CFG_IDX    = '0;
  logic [W-1:0]  CFG_VALUE  = '0;
  logic [W-1:0]  CFG_MASK   = '0;
  logic [1:0]    CFG_ACTION = '0;
  logic [W-1:0]  CFG_LOAD   = '0;
  logic          CFG_ENABLE = 1'b0;
  logic [W-1:0]  LED;
  logic          MATCH;
  logic [IW-1:0] MATCH_IDX;
`ifdef MATCH_COUNTER_STATUS_EN
  logic          STICKY_CLR = 1'b0;
  logic [N-1:0]  STICKY_HIT;
`endif

  int          vectors = 0;
  int          errs    = 0;
  logic [31:0] exp_q[$];

  match_counter #(
    .WIDTH    (W),
    .NUM_RULES(N),
    .STEP     (1)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .EN        (EN),
    .CFG_WE    (CFG_WE),
    .CFG_IDX   (CFG_IDX),
    .CFG_VALUE (CFG_VALUE),
    .CFG_MASK  (CFG_MASK),
    .CFG_ACTION(CFG_ACTION),
    .CFG_LOAD  (CFG_LOAD),
    .CFG_ENABLE(CFG_ENABLE),
    .LED       (LED),
    .MATCH     (MATCH),
    .MATCH_IDX (MATCH_IDX)
`ifdef MATCH_COUNTER_STATUS_EN
    ,
    .STICKY_CLR(STICKY_CLR),
    .STICKY_HIT(STICKY_HIT)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      errs++;
      $display("FAIL %s scoreboard empty, observed=%0h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errs++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic step(input string tag, input logic [7:0] v);
    push(32'(v));
    tick();
    check(tag, 32'(LED));
  endtask

  task automatic stat(input string tag, input logic m,
                      input logic [1:0] idx);
    push({29'd0, m, idx});
    check(tag, {29'd0, MATCH, MATCH_IDX});
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [7:0] val,
                     input logic [7:0] msk, input logic [1:0] act,
                     input logic [7:0] ld, input logic en);
    CFG_IDX    = idx;
    CFG_VALUE  = val;
    CFG_MASK   = msk;
    CFG_ACTION = act;
    CFG_LOAD   = ld;
    CFG_ENABLE = en;
    CFG_WE     = 1'b1;
    tick();
    CFG_WE     = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    push(32'd0);
    check("rst_led", 32'(LED));
    stat("rst_match", 1'b0, 2'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    EN    = 1'b1;

    // free run with wrap
    for (int i = 1; i <= 256; i++) begin
      step("free_run", 8'(i));
    end
    stat("free_nomatch", 1'b0, 2'd0);

    // wildcard clear at 2/3
    EN = 1'b0;
    cfg(2'd0, 8'h02, 8'hFE, ACT_CLEAR, 8'h00, 1'b1);
    EN = 1'b1;
    step("clr_1", 8'h01);
    stat("clr_miss", 1'b0, 2'd0);
    step("clr_2", 8'h02);
    stat("clr_hit", 1'b1, 2'd0);
    step("clr_0", 8'h00);
    step("clr_1b", 8'h01);
    step("clr_2b", 8'h02);
    EN = 1'b0;

    // load vs clear priority
    cfg(2'd0, 8'h00, 8'h00, ACT_INC, 8'h00, 1'b0);
    cfg(2'd0, 8'h05, 8'hFF, ACT_LOAD, 8'h40, 1'b1);
    cfg(2'd1, 8'h04, 8'hFC, ACT_CLEAR, 8'h00, 1'b1);
    EN = 1'b1;
    step("pri_3", 8'h03);
    step("pri_4", 8'h04);
    stat("pri_r1", 1'b1, 2'd1);
    step("pri_clr", 8'h00);
    EN = 1'b0;
    cfg(2'd1, 8'h04, 8'hFC, ACT_CLEAR, 8'h00, 1'b0);
    EN = 1'b1;
    step("pri_c1", 8'h01);
    step("pri_c2", 8'h02);
    step("pri_c3", 8'h03);
    step("pri_c4", 8'h04);
    stat("pri_r1_off", 1'b0, 2'd0);
    step("pri_c5", 8'h05);
    EN = 1'b0;
    stat("en0_match", 1'b1, 2'd0);
    cfg(2'd1, 8'h04, 8'hFC, ACT_CLEAR, 8'h00, 1'b1);
    stat("pri_both", 1'b1, 2'd0);
    EN = 1'b1;
    step("pri_load", 8'h40);
    EN = 1'b0;
    stat("pri_none", 1'b0, 2'd0);

    // hold rule, then enable-low hold
    cfg(2'd0, 8'h00, 8'h00, ACT_INC, 8'h00, 1'b0);
    cfg(2'd1, 8'h00, 8'h00, ACT_INC, 8'h00, 1'b0);
    cfg(2'd2, 8'h10, 8'hFF, ACT_HOLD, 8'h00, 1'b1);
    cfg(2'd3, 8'h40, 8'hFF, ACT_LOAD, 8'h0E, 1'b1);
    stat("hold_r3", 1'b1, 2'd3);
    EN = 1'b1;
    step("hold_0e", 8'h0E);
    step("hold_0f", 8'h0F);
    step("hold_10", 8'h10);
    stat("hold_r2", 1'b1, 2'd2);
    step("hold_st1", 8'h10);
    step("hold_st2", 8'h10);
    EN = 1'b0;
    cfg(2'd2, 8'h00, 8'h00, ACT_INC, 8'h00, 1'b0);
    cfg(2'd0, 8'h10, 8'hFF, ACT_LOAD, 8'h07, 1'b1);
    stat("ld7_r0", 1'b1, 2'd0);
    EN = 1'b1;
    step("ld7", 8'h07);
    EN = 1'b0;
    stat("en0_nomatch", 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      step("en0_hold", 8'h07);
    end

    // same-cycle rewrite uses the old table
    cfg(2'd0, 8'h03, 8'hFF, ACT_CLEAR, 8'h00, 1'b1);
    cfg(2'd1, 8'h07, 8'hFF, ACT_LOAD, 8'h02, 1'b1);
    EN = 1'b1;
    step("wr_2", 8'h02);
    step("wr_3", 8'h03);
    stat("wr_hit", 1'b1, 2'd0);
    CFG_IDX    = 2'd0;
    CFG_VALUE  = 8'h03;
    CFG_MASK   = 8'hFF;
    CFG_ACTION = ACT_CLEAR;
    CFG_ENABLE = 1'b0;
    CFG_WE     = 1'b1;
    step("wr_old", 8'h00);
    CFG_WE = 1'b0;
    step("wr_n1", 8'h01);
    step("wr_n2", 8'h02);
    step("wr_n3", 8'h03);
    step("wr_n4", 8'h04);
    stat("wr_gone", 1'b0, 2'd0);

    // all-don't-care rule matches anything
    EN = 1'b0;
    cfg(2'd3, 8'h00, 8'h00, ACT_HOLD, 8'h00, 1'b1);
    stat("mask0_hit", 1'b1, 2'd3);
    EN = 1'b1;
    step("mask0_h1", 8'h04);
    step("mask0_h2", 8'h04);
    EN = 1'b0;

    // async reset mid-count at 0x37
    cfg(2'd3, 8'h00, 8'h00, ACT_INC, 8'h00, 1'b0);
    cfg(2'd2, 8'h04, 8'hFF, ACT_LOAD, 8'h36, 1'b1);
    EN = 1'b1;
    step("pre_36", 8'h36);
    step("pre_37", 8'h37);
    #2;
    RST_N = 1'b0;
    #1;
    push(32'd0);
    check("arst_led", 32'(LED));
    stat("arst_match", 1'b0, 2'd0);
`ifdef MATCH_COUNTER_STATUS_EN
    push(32'd0);
    check("arst_sticky", 32'(STICKY_HIT));
`endif
    #1;
    RST_N = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step("post_rst", 8'(i));
      stat("post_rst_m", 1'b0, 2'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule

// File: doc/match_counter.md
MATCH_COUNTER -- requirements
Module: match_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and pattern width in bits (2..32).
REQ-002 SHALL have parameter NUM_RULES, default 4, number of wildcard match rules (1..16).
REQ-003 SHALL have parameter STEP, default 1, increment amount, taken modulo 2^WIDTH.
REQ-004 SHALL have port CLK  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port EN  input  1  count enable; when low, the counter holds.
REQ-007 SHALL have port CFG_WE  input  1  rule write strobe.
REQ-008 SHALL have port CFG_IDX  input  max(1,clog2(NUM_RULES))  index of the rule being written.
REQ-009 SHALL have port CFG_VALUE  input  WIDTH  match value.
REQ-010 SHALL have port CFG_MASK  input  WIDTH  care mask (1 = compare the bit, 0 = don't-care).
REQ-011 SHALL have port CFG_ACTION  input  2  action code: 00 INC, 01 CLEAR, 10 LOAD, 11 HOLD.
REQ-012 SHALL have port CFG_LOAD  input  WIDTH  value applied by the LOAD action.
REQ-013 SHALL have port CFG_ENABLE  input  1  rule valid bit.
REQ-014 SHALL have port LED  output  WIDTH  current count (registered).
REQ-015 SHALL have port MATCH  output  1  high when any valid rule matches LED (combinational).
REQ-016 SHALL have port MATCH_IDX  output  max(1,clog2(NUM_RULES))  index of the winning rule; 0 when MATCH is low.

Function
REQ-017 A rule SHALL match when it is valid and ((LED ^ VALUE) & MASK) == 0.
REQ-018 Priority SHALL go to the lowest matching index; higher-index matches are ignored.
REQ-019 With EN=1, the next LED SHALL follow the winning action: INC gives LED+STEP mod 2^WIDTH, CLEAR gives 0, LOAD gives the rule's LOAD value, HOLD leaves LED unchanged.
REQ-020 With EN=1 and no match, the default action SHALL be INC.
REQ-021 With EN=0, LED SHALL hold regardless of rules; MATCH and MATCH_IDX SHALL still reflect the current LED.
REQ-022 INC at 2^WIDTH-STEP or above SHALL wrap modulo 2^WIDTH, with no flag and no stall.
REQ-023 When CFG_WE=1, the rule at CFG_IDX SHALL be written at the clock edge and take effect from the next cycle.
REQ-024 The evaluation in a cycle with a simultaneous write SHALL use the pre-write rule table.
REQ-025 A CFG_IDX >= NUM_RULES SHALL be ignored, with no state change.
REQ-026 A rule with MASK=0 and valid=1 SHALL match every LED value.

Reset
REQ-027 While RST_N is low: LED=0, every rule's valid, VALUE, MASK, ACTION and LOAD fields = 0, and all status registers = 0.
REQ-028 Reset SHALL take effect immediately, without a clock, including mid-count or mid-write.
REQ-029 After reset the block SHALL behave as a free-running STEP counter starting at 0 on the first enabled edge.

Configuration
REQ-030 With macro MATCH_COUNTER_STATUS_EN defined, the block SHALL add input STICKY_CLR (1) and output STICKY_HIT (NUM_RULES).
REQ-031 With MATCH_COUNTER_STATUS_EN defined, bit i of STICKY_HIT SHALL set on any edge where EN=1 and rule i wins.
REQ-032 With MATCH_COUNTER_STATUS_EN defined, STICKY_CLR=1 SHALL clear all bits, and a set in the same cycle SHALL win.
REQ-033 Without MATCH_COUNTER_STATUS_EN, those ports and registers SHALL be absent and all other behaviour identical.

Structure
REQ-034 Package match_counter_pkg SHALL hold the action typedef (ACT_INC, ACT_CLEAR, ACT_LOAD, ACT_HOLD), the ACTION_W=2 constant and the rule struct typedef.
REQ-035 Sub-module match_counter_rule SHALL implement one rule's storage, write decode and match compare; NUM_RULES instances SHALL be generated.
REQ-036 The priority encoder and the counter register SHALL sit in the top level.

Verification (WIDTH=8, NUM_RULES=4, STEP=1)
REQ-037 Reset, EN=1, no rules: LED 0,1,2,...,0xFF,0x00; MATCH stays 0.
REQ-038 Rule0 = {VALUE 0x02, MASK 0xFE, CLEAR}: LED 0,1,2,0,1,2,...; MATCH=1 and MATCH_IDX=0 at LED=2.
REQ-039 Rule0 = {0x05, 0xFF, LOAD 0x40} and rule1 = {0x04, 0xFC, CLEAR}: LED=4 gives 0; after forcing LED=5 via rule1 disabled, 5 gives 0x40 (rule0 wins).
REQ-040 Rule2 = {0x10, 0xFF, HOLD}: LED sticks at 0x10; with EN=0 at LED=7, LED stays 7 for 5 cycles.
REQ-041 Rule0 = CLEAR at LED=3, and in the same cycle as LED=3 rule0 is rewritten to disabled: next LED is 0, then it counts 1,2,3,4.
REQ-042 RST_N pulsed low between edges at LED=0x37: LED reads 0 before the next edge, all rules are invalid, and STICKY_HIT=0 when MATCH_COUNTER_STATUS_EN is defined.
